// File: rtl/pipe_slice.sv
// pipe_slice
//   Valid/ready pipeline slice. It carries a WIDTH-bit payload through STAGES
//   cascaded register stages so that long handshake paths can be cut for timing.
//
//   MODE 0 : forward-registered stages. Each stage holds one beat. The stage
//            ready is ~v | ready_dn, so ready_i reaches ready_o combinationally
//            through the whole chain.
//   MODE 1 : skid-buffered stages. Each stage has a main register and a skid
//            register, so it holds up to two beats. The stage ready is ~sv, taken
//            straight from a flop, so ready_i has no combinational path to ready_o.
//
//   flush_i is a synchronous flush. It has priority over every load. On the next
//   edge it clears every valid bit and the occupancy count. While it is high,
//   ready_o is 1 and any offered input beat is dropped.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst      : asynchronous reset, active-high
//   valid_i  : upstream beat valid
//   data_i   : upstream payload
//   ready_o  : slice can accept a beat this cycle
//   valid_ro : registered downstream valid
//   data_ro  : registered downstream payload
//   ready_i  : downstream accepts
//   flush_i  : synchronous flush; discard all held beats
//   count_o  : number of beats currently held (registered)
module pipe_slice #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 1,
    parameter int unsigned MODE   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_i,
    input  logic [WIDTH-1:0]                data_i,
    output logic                            ready_o,
    output logic                            valid_ro,
    output logic [WIDTH-1:0]                data_ro,
    input  logic                            ready_i,
    input  logic                            flush_i,
    output logic [$clog2(2*STAGES+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(2*STAGES+1);

    // Per-stage view of the chain. Index k is stage k, and stage 0 faces the
    // upstream port.
    logic [STAGES-1:0] stg_v;    // stage output valid (main register)
    logic [STAGES-1:0] stg_sv;   // stage skid valid (always 0 in MODE 0)
    logic [WIDTH-1:0]  stg_d [STAGES];
    logic [STAGES-1:0] up_rdy;   // ready that stage k presents upstream
    logic [STAGES-1:0] dn_rdy;   // ready that stage k sees from downstream

    // Build the ready chain from the output end back to the input. In MODE 0
    // each stage ORs its own emptiness into the downstream ready. In MODE 1
    // each stage drives its ready from its skid flop, which breaks the chain.
    always_comb begin : ready_chain
        logic r;
        r      = ready_i;
        up_rdy = '0;
        dn_rdy = '0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            dn_rdy[STAGES-1-j] = r;
            if (MODE == 1) begin
                up_rdy[STAGES-1-j] = ~stg_sv[STAGES-1-j];
            end else begin
                up_rdy[STAGES-1-j] = ~stg_v[STAGES-1-j] | r;
            end
            r = up_rdy[STAGES-1-j];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_up;
        logic [WIDTH-1:0] d_up;

        if (k == 0) begin : g_head
            assign v_up = valid_i;
            assign d_up = data_i;
        end else begin : g_body
            assign v_up = stg_v[k-1];
            assign d_up = stg_d[k-1];
        end

        if (MODE == 0) begin : g_fwd
            logic             v_q;
            logic [WIDTH-1:0] d_q;
            logic             cke;

            assign cke = ~v_q | dn_rdy[k];

            // The payload is only captured alongside a valid beat. This keeps
            // the last payload steady while the stage drains to empty.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                end else if (flush_i) begin
                    v_q <= 1'b0;
                end else if (cke) begin
                    v_q <= v_up;
                    if (v_up) begin
                        d_q <= d_up;
                    end
                end
            end

            assign stg_v[k]  = v_q;
            assign stg_sv[k] = 1'b0;
            assign stg_d[k]  = d_q;
        end else begin : g_skid
            logic             v_q;
            logic             sv_q;
            logic [WIDTH-1:0] d_q;
            logic [WIDTH-1:0] sd_q;
            logic             acc;

            assign acc = v_up & ~sv_q;

            // When the skid register is occupied, upstream sees ready low, so
            // no new beat can arrive. The skid drains into main before anything
            // else moves, which keeps beats in order.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    sv_q <= 1'b0;
                    d_q  <= '0;
                    sd_q <= '0;
                end else if (flush_i) begin
                    v_q  <= 1'b0;
                    sv_q <= 1'b0;
                end else if (sv_q) begin
                    if (dn_rdy[k]) begin
                        d_q  <= sd_q;
                        sv_q <= 1'b0;
                    end
                end else if (acc) begin
                    if (~v_q | dn_rdy[k]) begin
                        v_q <= 1'b1;
                        d_q <= d_up;
                    end else begin
                        sv_q <= 1'b1;
                        sd_q <= d_up;
                    end
                end else if (dn_rdy[k]) begin
                    v_q <= 1'b0;
                end
            end

            assign stg_v[k]  = v_q;
            assign stg_sv[k] = sv_q;
            assign stg_d[k]  = d_q;
        end
    end

    assign valid_ro = stg_v[STAGES-1];
    assign data_ro  = stg_d[STAGES-1];

    // During a flush the offered beat is swallowed, so ready is forced high.
    assign ready_o = flush_i | up_rdy[0];

    logic          in_xfer;
    logic          out_xfer;
    logic [CW-1:0] count_q;

    assign in_xfer  = valid_i & up_rdy[0] & ~flush_i;
    assign out_xfer = valid_ro & ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_slice.sv
// tb_pipe_slice
//   Runs several pipe_slice configurations side by side:
//   (MODE,STAGES) = (0,1) (0,4) (1,1) (1,4) (0,3) (1,2).
//   Each instance has its own driver, occupancy predictor and output scoreboard.
module tb_pipe_slice;

    localparam int NI = 6;

    function automatic int cfg_mode(input int i);
        case (i)
            2, 3, 5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stg(input int i);
        case (i)
            0, 2:    return 1;
            1, 3:    return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    logic clk;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string nm, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", nm, inst, $time, act, exp);
        end
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int MD  = cfg_mode(g);
        localparam int STG = cfg_stg(g);
        localparam int CAP = (MD == 1) ? 2 * STG : STG;
        localparam int CW  = $clog2(2 * STG + 1);

        logic          rst;
        logic          valid_i;
        logic [7:0]    data_i;
        logic          ready_o;
        logic          valid_ro;
        logic [7:0]    data_ro;
        logic          ready_i;
        logic          flush_i;
        logic [CW-1:0] count_o;

        pipe_slice #(.WIDTH(8), .STAGES(STG), .MODE(MD)) dut (
            .clk      (clk),
            .rst      (rst),
            .valid_i  (valid_i),
            .data_i   (data_i),
            .ready_o  (ready_o),
            .valid_ro (valid_ro),
            .data_ro  (data_ro),
            .ready_i  (ready_i),
            .flush_i  (flush_i),
            .count_o  (count_o)
        );

        // Expected output beats in the order they were accepted.
        logic [7:0] sb [$];

        // Reference model: each stage is a small queue that holds at most
        // 1 beat (MODE 0) or 2 beats (MODE 0 only tracks emptiness, MODE 1
        // tracks fill level). The payload order comes from sb.
        int occ  [STG];
        bit mup  [STG];
        bit mmv  [STG];
        bit rdn;
        bit acc;
        int tot;

        always @(negedge clk) begin
            if (rst) begin
                for (int k = 0; k < STG; k++) occ[k] = 0;
                check("rst_valid", g, int'(valid_ro), 0);
                check("rst_count", g, int'(count_o), 0);
                check("rst_data",  g, int'(data_ro), 0);
                check("rst_ready", g, int'(ready_o), 1);
            end else begin
                rdn = ready_i;
                tot = 0;
                for (int k = STG - 1; k >= 0; k--) begin
                    if (MD == 1) mup[k] = (occ[k] < 2);
                    else         mup[k] = (occ[k] == 0) || rdn;
                    mmv[k] = (occ[k] > 0) && rdn;
                    rdn    = mup[k];
                    tot    = tot + occ[k];
                end
                check("ready_o", g, int'(ready_o), int'(flush_i || mup[0]));
                check("valid_ro", g, int'(valid_ro), int'(occ[STG-1] > 0));
                check("count_o", g, int'(count_o), tot);
                acc = valid_i && mup[0] && !flush_i;
                if (acc) sb.push_back(data_i);
                if (flush_i) begin
                    for (int k = 0; k < STG; k++) occ[k] = 0;
                end else begin
                    for (int k = 0; k < STG; k++)
                        occ[k] = occ[k] - int'(mmv[k]) + ((k == 0) ? int'(acc) : int'(mmv[k-1]));
                end
            end
        end

        // Output monitor: every downstream transfer must match the oldest
        // beat that is still expected.
        logic [7:0] expd;
        always @(negedge clk) begin
            if (rst) begin
                sb.delete();
            end else begin
                if (valid_ro && ready_i) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected", g, 1, 0);
                    end else begin
                        expd = sb.pop_front();
                        check("sb_data", g, int'(data_ro), int'(expd));
                    end
                end
                if (flush_i) sb.delete();
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            valid_i = 1'b0;
            flush_i = 1'b0;
            ready_i = 1'b1;
            repeat (CAP + 3) step();
        endtask

        initial begin : drive
            logic r0;
            rst     = 1'b1;
            valid_i = 1'b0;
            data_i  = '0;
            ready_i = 1'b0;
            flush_i = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;

            // Reset mid-stream with two beats held.
            if (CAP >= 2) begin
                valid_i = 1'b1; data_i = 8'h31; step();
                data_i = 8'h32; step();
                valid_i = 1'b0;
                check("pre_rst_count", g, int'(count_o), 2);
                rst = 1'b1;
                #1;
                check("async_rst_valid", g, int'(valid_ro), 0);
                check("async_rst_count", g, int'(count_o), 0);
                check("async_rst_data",  g, int'(data_ro), 0);
                step();
                rst = 1'b0;
                #1;
                check("post_rst_ready", g, int'(ready_o), 1);
            end

            // Full-rate stream: 1..10 must come out on back-to-back cycles,
            // with each beat 3 cycles after it went in.
            if (MD == 0 && STG == 3) begin
                drain();
                ready_i = 1'b1;
                for (int c = 0; c <= 12; c++) begin
                    if (c == 2) check("stream_gap", g, int'(valid_ro), 0);
                    if (c >= 3) begin
                        check("stream_valid", g, int'(valid_ro), 1);
                        check("stream_data",  g, int'(data_ro), c - 2);
                    end
                    valid_i = (c < 10);
                    data_i  = 8'(c + 1);
                    step();
                end
                valid_i = 1'b0;
            end

            // Backpressure: only four of the six offered beats fit.
            if (MD == 1 && STG == 2) begin
                drain();
                ready_i = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    valid_i = 1'b1;
                    data_i  = 8'(8'hA0 + i);
                    step();
                end
                valid_i = 1'b0;
                check("bp_ready", g, int'(ready_o), 0);
                check("bp_count", g, int'(count_o), 4);
                ready_i = 1'b1;
                repeat (6) step();
                check("bp_empty", g, int'(count_o), 0);
            end

            // Stall hold: valid_ro/data_ro must not change while ready_i=0.
            drain();
            ready_i = 1'b0;
            valid_i = 1'b1;
            data_i  = 8'h5C;
            step();
            valid_i = 1'b0;
            for (int w = 0; w < STG + 2 && !valid_ro; w++) step();
            check("hold_valid", g, int'(valid_ro), 1);
            check("hold_data",  g, int'(data_ro), 8'h5C);
            for (int i = 0; i < 5; i++) begin
                valid_i = 1'($urandom_range(0, 1));
                data_i  = 8'($urandom);
                step();
                check("hold_valid", g, int'(valid_ro), 1);
                check("hold_data",  g, int'(data_ro), 8'h5C);
            end
            valid_i = 1'b0;

            // Flush with three beats held and a beat offered in the same cycle.
            if (CAP >= 3) begin
                drain();
                ready_i = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    valid_i = 1'b1;
                    data_i  = 8'(8'h10 + i);
                    step();
                end
                valid_i = 1'b0;
                check("pre_flush_count", g, int'(count_o), 3);
                flush_i = 1'b1;
                valid_i = 1'b1;
                data_i  = 8'h77;
                #1;
                check("flush_ready", g, int'(ready_o), 1);
                step();
                flush_i = 1'b0;
                valid_i = 1'b0;
                check("flush_count", g, int'(count_o), 0);
                check("flush_valid", g, int'(valid_ro), 0);
                ready_i = 1'b1;
                repeat (CAP + 2) begin
                    step();
                    check("flush_quiet", g, int'(valid_ro), 0);
                end
            end

            // Random traffic. ready_i switches between sparse, medium and dense
            // phases so the slice both fills up and drains.
            for (int c = 0; c < 400; c++) begin
                int pr;
                pr = ((c / 40) % 3 == 0) ? 15 : (((c / 40) % 3 == 1) ? 55 : 95);
                valid_i = ($urandom_range(0, 99) < 65);
                data_i  = 8'($urandom);
                ready_i = ($urandom_range(0, 99) < pr);
                flush_i = ($urandom_range(0, 99) < 2);
                if (MD == 1) begin
                    #1;
                    r0 = ready_o;
                    ready_i = ~ready_i;
                    #1;
                    check("no_comb_ready", g, int'(ready_o), int'(r0));
                    ready_i = ~ready_i;
                end
                step();
            end

            drain();
            check("final_count", g, int'(count_o), 0);
            check("sb_leftover", g, sb.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && done_cnt < NI; t++) @(posedge clk);
        if (done_cnt < NI) begin
            checks++;
            failures++;
            $display("FAIL timeout done=%0d expected=%0d", done_cnt, NI);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
